// File: rtl/vdma_vout_pkg.sv
// Shared types for the VDMA video output stage: FSM encoding and the
// per-axis timing configuration captured by the timing generator.
package vdma_vout_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 12;

  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef struct packed {
    cnt_t active;
    cnt_t sync_start;
    cnt_t sync_end;
    cnt_t total;
  } timing_cfg_t;

endpackage

// File: rtl/vdma_vtc.sv
// Video timing counters: shadowed timing config, h/v counters and the raw
// active/sync/wrap strobes for the current counter position.
module vdma_vtc
  import vdma_vout_pkg::*;
(
  input  logic        aclk,
  input  logic        rst,
  input  logic        run,
  input  timing_cfg_t h_cfg,
  input  timing_cfg_t v_cfg,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        wrap,
  output logic        h_last_act,
  output logic        v_last_act
);

  timing_cfg_t h_sh_q, h_sh_d, v_sh_q, v_sh_d;
  cnt_t        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        h_end_s, v_end_s;

  // Next-state for counters and shadows; config only moves at a frame boundary.
  always_comb begin
    h_end_s = (hcnt_q == (h_sh_q.total - CNT_ONE));
    v_end_s = (vcnt_q == (v_sh_q.total - CNT_ONE));
    wrap    = run && h_end_s && v_end_s;
    if (!run) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_end_s) begin
      hcnt_d = '0;
      vcnt_d = v_end_s ? '0 : (vcnt_q + CNT_ONE);
    end else begin
      hcnt_d = hcnt_q + CNT_ONE;
      vcnt_d = vcnt_q;
    end
    if (!run || wrap) begin
      h_sh_d = h_cfg;
      v_sh_d = v_cfg;
    end else begin
      h_sh_d = h_sh_q;
      v_sh_d = v_sh_q;
    end
  end

  assign active     = (hcnt_q < h_sh_q.active) && (vcnt_q < v_sh_q.active);
  assign hsync      = (hcnt_q >= h_sh_q.sync_start) && (hcnt_q < h_sh_q.sync_end);
  assign vsync      = (vcnt_q >= v_sh_q.sync_start) && (vcnt_q < v_sh_q.sync_end);
  assign h_last_act = (hcnt_q == (h_sh_q.active - CNT_ONE));
  assign v_last_act = (vcnt_q == (v_sh_q.active - CNT_ONE));

  // Counter and shadow state.
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      h_sh_q <= '0;
      v_sh_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      h_sh_q <= h_sh_d;
      v_sh_q <= v_sh_d;
    end
  end

endmodule

// File: rtl/vdma_vout.sv
// VDMA display output: locks the pixel stream to the raster produced by
// vdma_vtc, flags underflow / misalignment and relocks at frame boundaries.
module vdma_vout
  import vdma_vout_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter logic                  HS_POL     = 1'b1,
  parameter logic                  VS_POL     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] BLANK_PIX  = '0
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  cfg_enable,
  input  logic [CNT_WIDTH-1:0]  cfg_h_active,
  input  logic [CNT_WIDTH-1:0]  cfg_h_sync_start,
  input  logic [CNT_WIDTH-1:0]  cfg_h_sync_end,
  input  logic [CNT_WIDTH-1:0]  cfg_h_total,
  input  logic [CNT_WIDTH-1:0]  cfg_v_active,
  input  logic [CNT_WIDTH-1:0]  cfg_v_sync_start,
  input  logic [CNT_WIDTH-1:0]  cfg_v_sync_end,
  input  logic [CNT_WIDTH-1:0]  cfg_v_total,
  input  logic                  cfg_err_clear,
  output logic                  vid_hsync,
  output logic                  vid_vsync,
  output logic                  vid_de,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  sts_locked,
  output logic                  sts_underflow,
  output logic                  sts_sync_err,
  output logic [15:0]           sts_frame_cnt
);

  state_e                  state_q, state_d;
  logic                    de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    locked_q, locked_d, frame_ok_q, frame_ok_d;
  logic                    underflow_q, underflow_d, sync_err_q, sync_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    run_s, tready_s, hs_s, mismatch_s, uf_set_s, se_set_s;
  logic                    active_s, hsync_s, vsync_s, wrap_s, h_last_s, v_last_s;
  timing_cfg_t             h_cfg_s, v_cfg_s;

  assign h_cfg_s = '{active: cfg_h_active, sync_start: cfg_h_sync_start,
                     sync_end: cfg_h_sync_end, total: cfg_h_total};
  assign v_cfg_s = '{active: cfg_v_active, sync_start: cfg_v_sync_start,
                     sync_end: cfg_v_sync_end, total: cfg_v_total};

  // Counters stop in the same cycle enable drops so IDLE always sees them at 0.
  assign run_s = cfg_enable && (state_q != ST_IDLE);

  vdma_vtc u_vtc (
    .aclk       (aclk),
    .rst        (rst),
    .run        (run_s),
    .h_cfg      (h_cfg_s),
    .v_cfg      (v_cfg_s),
    .active     (active_s),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .wrap       (wrap_s),
    .h_last_act (h_last_s),
    .v_last_act (v_last_s)
  );

  assign tready_s      = cfg_enable && ((state_q == ST_FLUSH) ||
                                        ((state_q == ST_LOCKED) && active_s));
  assign s_axis_tready = tready_s;

  // FSM transitions, stream checks and next values of every registered output.
  always_comb begin
    hs_s       = s_axis_tvalid && tready_s;
    mismatch_s = (s_axis_tuser != h_last_s) ||
                 (s_axis_tlast != (s_axis_tuser && v_last_s));
    state_d    = state_q;
    uf_set_s   = 1'b0;
    se_set_s   = 1'b0;
    data_d     = BLANK_PIX;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FLUSH;
        ST_FLUSH: state_d = (hs_s && s_axis_tlast) ? ST_WAIT : ST_FLUSH;
        ST_WAIT:  state_d = wrap_s ? ST_LOCKED : ST_WAIT;
        ST_LOCKED: begin
          if (active_s && !s_axis_tvalid) begin
            uf_set_s = 1'b1;
            state_d  = ST_FLUSH;
          end else if (hs_s) begin
            data_d = s_axis_tdata;
            if (mismatch_s) begin
              se_set_s = 1'b1;
              state_d  = s_axis_tlast ? ST_WAIT : ST_FLUSH;
            end else begin
              state_d = ST_LOCKED;
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
    de_d     = run_s && active_s;
    hsync_d  = (run_s && hsync_s) ? HS_POL : ~HS_POL;
    vsync_d  = (run_s && vsync_s) ? VS_POL : ~VS_POL;
    locked_d = (state_d == ST_LOCKED);
    // Frame counts only if LOCKED was held from one wrap to the next.
    frame_ok_d = (wrap_s || frame_ok_q) && (state_d == ST_LOCKED);
    if (wrap_s && (state_q == ST_LOCKED) && frame_ok_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (uf_set_s) begin
      underflow_d = 1'b1;
    end else if (cfg_err_clear) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
    if (se_set_s) begin
      sync_err_d = 1'b1;
    end else if (cfg_err_clear) begin
      sync_err_d = 1'b0;
    end else begin
      sync_err_d = sync_err_q;
    end
  end

  // State, video outputs and status registers.
  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      de_q        <= 1'b0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      data_q      <= BLANK_PIX;
      locked_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      data_q      <= data_d;
      locked_q    <= locked_d;
      frame_ok_q  <= frame_ok_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vid_de        = de_q;
  assign vid_hsync     = hsync_q;
  assign vid_vsync     = vsync_q;
  assign vid_data      = data_q;
  assign sts_locked    = locked_q;
  assign sts_underflow = underflow_q;
  assign sts_sync_err  = sync_err_q;
  assign sts_frame_cnt = frame_cnt_q;

endmodule

// File: doc/vdma_vout.md
Name: vdma_vout

Overview:
- Downstream display stage for the VDMA read engine. Consumes its AXI-Stream pixels: one pixel per beat, tuser marks end of line, tlast marks end of frame.
- Generates video timing (hsync/vsync/de) from programmable counters and drives pixel data out.
- Locks the stream to the raster, detects underflow and line/frame misalignment, and recovers automatically at the next frame boundary.

Parameters:
- DATA_WIDTH, 32, pixel/beat width; must match the upstream VDMA stream width.
- CNT_WIDTH, 12, width of the horizontal/vertical counters and timing config fields.
- HS_POL, 1'b1, active level of vid_hsync.
- VS_POL, 1'b1, active level of vid_vsync.
- BLANK_PIX, 0, value driven on vid_data during blanking and underflow.

Ports:
- aclk  in  1  pixel/stream clock
- rst  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  pixel valid
- s_axis_tready  out  1  pixel accept
- s_axis_tdata  in  DATA_WIDTH  pixel
- s_axis_tuser  in  1  last pixel of line
- s_axis_tlast  in  1  last pixel of frame
- cfg_enable  in  1  run; 0 forces IDLE
- cfg_h_active / cfg_h_sync_start / cfg_h_sync_end / cfg_h_total  in  CNT_WIDTH each  horizontal timing, in pixels
- cfg_v_active / cfg_v_sync_start / cfg_v_sync_end / cfg_v_total  in  CNT_WIDTH each  vertical timing, in lines
- cfg_err_clear  in  1  pulse; clears sticky errors
- vid_hsync / vid_vsync / vid_de  out  1 each  timing outputs
- vid_data  out  DATA_WIDTH  pixel out
- sts_locked  out  1  state==LOCKED
- sts_underflow  out  1  sticky
- sts_sync_err  out  1  sticky
- sts_frame_cnt  out  16  frames completed while LOCKED; wraps

Behaviour:
- Reset: state IDLE, counters 0. vid_de=0, vid_hsync=~HS_POL, vid_vsync=~VS_POL, vid_data=BLANK_PIX, s_axis_tready=0, all sts_* 0.
- Config precondition: 1 <= active < sync_start < sync_end <= total-1. Otherwise behaviour is undefined.
- Shadow registers capture cfg_* while in IDLE and on the counter wrap (hcnt==h_total-1 && vcnt==v_total-1). Mid-frame cfg changes have no effect until the wrap.
- Counters run whenever state != IDLE:
  - hcnt 0..h_total-1.
  - vcnt increments on hcnt wrap, range 0..v_total-1.
  - active = hcnt<h_active && vcnt<v_active.
  - hsync asserted for h_sync_start <= hcnt < h_sync_end; vsync is the vcnt analogue.
- Outputs are registered with 1-cycle latency from the counters. vid_data is latched from the beat accepted in the same cycle.
- States:
  - IDLE: tready=0, counters held at 0. Leaves to FLUSH when cfg_enable=1.
  - FLUSH: tready=1, beats discarded. On a tlast handshake go to WAIT.
  - WAIT: tready=0. On the counter wrap go to LOCKED, so the next cycle is pixel (0,0).
  - LOCKED: tready=active (combinational).
- LOCKED checks:
  - Active cycle with tvalid=0: vid_data=BLANK_PIX with de=1, set sts_underflow, go to FLUSH.
  - Accepted beat with tuser != (hcnt==h_active-1), or tlast != (tuser && vcnt==v_active-1): set sts_sync_err. Go to WAIT if that beat had tlast=1, else FLUSH. The pixel is still output.
- sts_frame_cnt increments at the wrap when state was LOCKED for the whole frame, i.e. LOCKED and no error in the frame.
- cfg_enable=0 at any time: next cycle is IDLE with outputs at reset values. Sticky bits are kept.
- cfg_err_clear clears sticky bits. An error in the same cycle wins.
- Asynchronous reset mid-frame returns every register to its reset value immediately.

Decomposition:
- Package vdma_vout_pkg: state encoding (IDLE, FLUSH, WAIT, LOCKED), CNT_WIDTH default, timing-config struct typedef.
- Sub-module vdma_vtc: shadow registers, h/v counters, raw active/hsync/vsync/wrap strobes.
- vdma_vout: FSM, stream checks, output registers, status.

Test Plan:
- Timing h=4/5/6/8 (active/sync_start/sync_end/total) and v=2/3/4/5. Enable with a continuous well-formed stream of 8-pixel frames with tdata=index -> 8 tready beats discarded in FLUSH; WAIT lasts until the first wrap; then each frame shows de high for 4 cycles on lines 0-1 with data 0..7, hsync high at hcnt 5, vsync high on line 3. sts_frame_cnt=1 after the first locked frame.
- Deassert tvalid at pixel 5 of a locked frame -> de=1 with data=BLANK_PIX that cycle; sts_underflow=1; FLUSH until tlast; relock; frame_cnt resumes.
- Send tuser on pixel 2 instead of 3 -> sts_sync_err=1, FLUSH, relock at the next frame boundary.
- Change cfg_h_active from 4 to 3 at vcnt=1 -> current frame keeps 4-pixel lines; the next frame uses 3-pixel lines. The stream generator switches in step.
- Deassert cfg_enable mid-line -> next cycle de=0, syncs inactive, tready=0. Re-enable -> FLUSH path again.
- Assert rst at vcnt=1 -> all outputs at reset values immediately; sts_* are 0 after release.
